// File: rtl/frame_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding and
// the lane-to-word packing helper.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Number of memory words one step occupies: ceil(lane_count / lanes_per_word).
  // A non-positive packing factor degenerates to one lane per word.
  function automatic int words_per_step(input int lane_count, input int lanes_per_word);
    if (lanes_per_word <= 0) begin
      return lane_count;
    end else begin
      return (lane_count + lanes_per_word - 1) / lanes_per_word;
    end
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Address generator: holds the current request address and the start
// address of the current frame, plus the stride settings captured at start.
module frame_addr_gen
  import frame_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int STRIDE_WIDTH   = 8,
  parameter int LANE_COUNT     = 15,
  parameter int LANES_PER_WORD = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    step_adv,
  input  logic                    frame_adv,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [STRIDE_WIDTH-1:0] lane_stride,
  input  logic [ADDR_WIDTH-1:0]   frame_stride,
  output logic [ADDR_WIDTH-1:0]   mem_addr
);

  localparam int WORDS_PER_STEP = words_per_step(LANE_COUNT, LANES_PER_WORD);

  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH-1:0]   frame_base_r;
  logic [STRIDE_WIDTH-1:0] lane_stride_r;
  logic [ADDR_WIDTH-1:0]   frame_stride_r;
  logic [ADDR_WIDTH-1:0]   step_inc_s;
  logic [ADDR_WIDTH-1:0]   next_frame_s;

  // Address increments; all sums wrap modulo 2^ADDR_WIDTH by truncation.
  assign step_inc_s   = ADDR_WIDTH'(lane_stride_r) * ADDR_WIDTH'(WORDS_PER_STEP);
  assign next_frame_s = frame_base_r + frame_stride_r;

  // Capture strides and base on start; step or jump to the next frame on advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r         <= {ADDR_WIDTH{1'b0}};
      frame_base_r   <= {ADDR_WIDTH{1'b0}};
      lane_stride_r  <= {STRIDE_WIDTH{1'b0}};
      frame_stride_r <= {ADDR_WIDTH{1'b0}};
    end else if (load) begin
      addr_r         <= base_addr;
      frame_base_r   <= base_addr;
      lane_stride_r  <= lane_stride;
      frame_stride_r <= frame_stride;
    end else if (frame_adv) begin
      addr_r         <= next_frame_s;
      frame_base_r   <= next_frame_s;
    end else if (step_adv) begin
      addr_r         <= addr_r + step_inc_s;
    end
  end

  assign mem_addr = addr_r;

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: walks frame_count frames of frame_depth steps each,
// issuing one memory request per step under mem_ready backpressure.
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH_WIDTH    = 16,
  parameter int STRIDE_WIDTH   = 8,
  parameter int LANE_COUNT     = 15,
  parameter int LANES_PER_WORD = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [DEPTH_WIDTH-1:0]  frame_depth,
  input  logic [STRIDE_WIDTH-1:0] lane_stride,
  input  logic [DEPTH_WIDTH-1:0]  frame_count,
  input  logic [ADDR_WIDTH-1:0]   frame_stride,
  input  logic                    start_trigger,
  input  logic                    abort,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    engine_enable,
  output logic                    busy,
  output logic [DEPTH_WIDTH-1:0]  step_index,
  output logic [DEPTH_WIDTH-1:0]  frame_index,
  output logic                    frame_done,
  output logic                    seq_done,
  output logic                    aborted
);

  seq_state_t state_r, state_next_s;

  logic [DEPTH_WIDTH-1:0] depth_r;
  logic [DEPTH_WIDTH-1:0] count_r;

  logic                   mem_req_r, engine_enable_r, busy_r;
  logic [DEPTH_WIDTH-1:0] step_index_r, frame_index_r;
  logic                   frame_done_r, seq_done_r, aborted_r;

  logic                   mem_req_s, engine_enable_s, busy_s;
  logic [DEPTH_WIDTH-1:0] step_index_s, frame_index_s;
  logic                   frame_done_s, seq_done_s, aborted_s;
  logic                   load_s, step_adv_s, frame_adv_s;

  logic start_s, depth_nonzero_s, transfer_s, last_step_s, last_frame_s;

  assign start_s         = (state_r == ST_IDLE) && start_trigger;
  assign depth_nonzero_s = (frame_depth != {DEPTH_WIDTH{1'b0}});
  assign transfer_s      = mem_req_r && mem_ready;
  assign last_step_s     = (step_index_r == (depth_r - DEPTH_WIDTH'(1)));
  assign last_frame_s    = (frame_index_r == (count_r - DEPTH_WIDTH'(1)));

  // Latch depth and frame count on an accepted start (a count of 0 means 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_r <= {DEPTH_WIDTH{1'b0}};
      count_r <= {DEPTH_WIDTH{1'b0}};
    end else if (start_s) begin
      depth_r <= frame_depth;
      count_r <= (frame_count == {DEPTH_WIDTH{1'b0}}) ? DEPTH_WIDTH'(1) : frame_count;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; abort wins over a simultaneous transfer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_trigger) begin
          state_next_s = depth_nonzero_s ? ST_RUN : ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (transfer_s && last_step_s && last_frame_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and address-generator commands.
  always_comb begin
    mem_req_s       = mem_req_r;
    engine_enable_s = engine_enable_r;
    busy_s          = busy_r;
    step_index_s    = step_index_r;
    frame_index_s   = frame_index_r;
    frame_done_s    = 1'b0;
    seq_done_s      = 1'b0;
    aborted_s       = 1'b0;
    load_s          = 1'b0;
    step_adv_s      = 1'b0;
    frame_adv_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_trigger) begin
          load_s          = 1'b1;
          step_index_s    = {DEPTH_WIDTH{1'b0}};
          frame_index_s   = {DEPTH_WIDTH{1'b0}};
          busy_s          = 1'b1;
          mem_req_s       = depth_nonzero_s;
          engine_enable_s = depth_nonzero_s;
        end else begin
          mem_req_s       = 1'b0;
          engine_enable_s = 1'b0;
          busy_s          = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          mem_req_s       = 1'b0;
          engine_enable_s = 1'b0;
          busy_s          = 1'b0;
          aborted_s       = 1'b1;
        end else if (transfer_s) begin
          if (!last_step_s) begin
            step_index_s  = step_index_r + DEPTH_WIDTH'(1);
            step_adv_s    = 1'b1;
          end else if (!last_frame_s) begin
            step_index_s  = {DEPTH_WIDTH{1'b0}};
            frame_index_s = frame_index_r + DEPTH_WIDTH'(1);
            frame_adv_s   = 1'b1;
            frame_done_s  = 1'b1;
          end else begin
            frame_done_s    = 1'b1;
            mem_req_s       = 1'b0;
            engine_enable_s = 1'b0;
          end
        end else begin
          mem_req_s = mem_req_r;
        end
      end
      ST_DONE: begin
        mem_req_s       = 1'b0;
        engine_enable_s = 1'b0;
        busy_s          = 1'b0;
        seq_done_s      = 1'b1;
      end
      default: begin
        mem_req_s       = 1'b0;
        engine_enable_s = 1'b0;
        busy_s          = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_r       <= 1'b0;
      engine_enable_r <= 1'b0;
      busy_r          <= 1'b0;
      step_index_r    <= {DEPTH_WIDTH{1'b0}};
      frame_index_r   <= {DEPTH_WIDTH{1'b0}};
      frame_done_r    <= 1'b0;
      seq_done_r      <= 1'b0;
      aborted_r       <= 1'b0;
    end else begin
      mem_req_r       <= mem_req_s;
      engine_enable_r <= engine_enable_s;
      busy_r          <= busy_s;
      step_index_r    <= step_index_s;
      frame_index_r   <= frame_index_s;
      frame_done_r    <= frame_done_s;
      seq_done_r      <= seq_done_s;
      aborted_r       <= aborted_s;
    end
  end

  frame_addr_gen #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .STRIDE_WIDTH   (STRIDE_WIDTH),
    .LANE_COUNT     (LANE_COUNT),
    .LANES_PER_WORD (LANES_PER_WORD)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load         (load_s),
    .step_adv     (step_adv_s),
    .frame_adv    (frame_adv_s),
    .base_addr    (base_addr),
    .lane_stride  (lane_stride),
    .frame_stride (frame_stride),
    .mem_addr     (mem_addr)
  );

  assign mem_req       = mem_req_r;
  assign engine_enable = engine_enable_r;
  assign busy          = busy_r;
  assign step_index    = step_index_r;
  assign frame_index   = frame_index_r;
  assign frame_done    = frame_done_r;
  assign seq_done      = seq_done_r;
  assign aborted       = aborted_r;

endmodule
